sram_rr_arbiter: RTL and testbench

- Parametrised single-clock round-robin arbiter between NW write channels and NR read channels, driving one SRAM controller port.
- Sits behind the per-channel clock-crossing FIFOs, in the sram_clock domain, and replaces the fixed 2W/2R arbiter.
- Read responses are routed by an internal tag queue, not a fixed delay chain, so SRAM read latency may vary.
- Fairness is a true rotating-pointer round robin across all NW+NR channels.

---
 rtl/sram_arb_pkg.sv | 33 +++
 rtl/sram_arb_tag_fifo.sv | 44 ++++
 rtl/sram_rr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sram_rr_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants and helpers for the SRAM round-robin arbiter and its write-FIFO producers.
package sram_arb_pkg;

  localparam logic CMD_EMPTY = 1'b0;
  localparam logic CMD_HOLD  = 1'b1;

  // Write entry layout is {mask, addr, data} with data in the least significant bits.
  localparam int FLD_DATA_LSB = 0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  function automatic int fld_addr_lsb(input int data_w);
    return FLD_DATA_LSB + data_w;
  endfunction

  function automatic int fld_mask_lsb(input int addr_w, input int data_w);
    return FLD_DATA_LSB + data_w + addr_w;
  endfunction

  function automatic int entry_w(input int mask_w, input int addr_w, input int data_w);
    return mask_w + addr_w + data_w;
  endfunction

  function automatic int slice_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/sram_arb_tag_fifo.sv
// Small synchronous FIFO holding the reader index of every outstanding SRAM read.
module sram_arb_tag_fifo
  import sram_arb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter of NW write and NR read channels onto one SRAM command port,
// with tag-routed read responses. Define SRAM_ARB_STATS_EN for per-channel grant counters.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NW        = 2,
  parameter int NR        = 2,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 32,
  parameter int MASK_W    = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                                sram_clock,
  input  logic                                reset_n,
  input  logic [NW-1:0]                       wr_valid,
  output logic [NW-1:0]                       wr_ready,
  input  logic [NW*(MASK_W+ADDR_W+DATA_W)-1:0] wr_din,
  input  logic [NR-1:0]                       rd_valid,
  output logic [NR-1:0]                       rd_ready,
  input  logic [NR*ADDR_W-1:0]                rd_addr,
  input  logic [NR-1:0]                       rd_resp_full,
  output logic [NR-1:0]                       rd_resp_valid,
  output logic [DATA_W-1:0]                   rd_resp_data,
  output logic                                sram_addr_valid,
  input  logic                                sram_ready,
  output logic [ADDR_W-1:0]                   sram_addr,
  output logic [DATA_W-1:0]                   sram_data_in,
  output logic [MASK_W-1:0]                   sram_write_mask,
  input  logic [DATA_W-1:0]                   sram_data_out,
  input  logic                                sram_data_out_valid,
  output logic                                err_orphan
`ifdef SRAM_ARB_STATS_EN
  , input  logic                              stat_clear
  , output logic [(NW+NR)*16-1:0]             stat_grants
`endif
);

  localparam int N        = NW + NR;
  localparam int PTR_W    = clog2(N);
  localparam int TAG_W    = (NR > 1) ? clog2(NR) : 1;
  localparam int EW       = entry_w(MASK_W, ADDR_W, DATA_W);
  localparam int ADDR_LSB = fld_addr_lsb(DATA_W);
  localparam int MASK_LSB = fld_mask_lsb(ADDR_W, DATA_W);

  logic [EW-1:0]     wr_entry    [NW];
  logic [ADDR_W-1:0] rd_addr_arr [NR];
  logic [N-1:0]      eligible;
  logic              tag_full;
  logic              tag_empty;
  logic [TAG_W-1:0]  tag_head;
  logic              cmd_state_reg;
  logic [PTR_W-1:0]  ptr_reg;
  logic [PTR_W-1:0]  ptr_next;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_found;
  logic              can_load;
  logic              grant_ok;
  logic              push_tag;
  logic [TAG_W-1:0]  push_tag_data;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] data_next;
  logic [MASK_W-1:0] mask_next;
  logic [NR-1:0]     resp_onehot;
  int                scan_idx;

  for (genvar gi = 0; gi < NW; gi++) begin : g_wr
    assign wr_entry[gi] = wr_din[slice_lsb(gi, EW) +: EW];
    assign eligible[gi] = wr_valid[gi];
    assign wr_ready[gi] = reset_n && grant_ok && (gnt_idx == PTR_W'(gi));
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_rd
    assign rd_addr_arr[gi]   = rd_addr[slice_lsb(gi, ADDR_W) +: ADDR_W];
    assign eligible[NW+gi]   = rd_valid[gi] && !rd_resp_full[gi] && !tag_full;
    assign rd_ready[gi]      = reset_n && grant_ok && (gnt_idx == PTR_W'(NW + gi));
    assign resp_onehot[gi]   = sram_data_out_valid && !tag_empty && (tag_head == TAG_W'(gi));
  end

  assign can_load = (cmd_state_reg == CMD_EMPTY) || sram_ready;
  assign grant_ok = can_load && gnt_found;
  assign push_tag = grant_ok && (gnt_idx >= PTR_W'(NW));
  assign ptr_next = (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + PTR_W'(1);

  // First eligible channel at or above the pointer, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < N; k++) begin
      scan_idx = int'(ptr_reg) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!gnt_found && eligible[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(scan_idx);
      end
    end
  end

  always_comb begin
    addr_next     = '0;
    data_next     = '0;
    mask_next     = '0;
    push_tag_data = '0;
    for (int i = 0; i < NW; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        mask_next = wr_entry[i][MASK_LSB +: MASK_W];
        addr_next = wr_entry[i][ADDR_LSB +: ADDR_W];
        data_next = wr_entry[i][FLD_DATA_LSB +: DATA_W];
      end
    end
    for (int j = 0; j < NR; j++) begin
      if (gnt_idx == PTR_W'(NW + j)) begin
        addr_next     = rd_addr_arr[j];
        push_tag_data = TAG_W'(j);
      end
    end
  end

  sram_arb_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (sram_clock),
    .rst_n     (reset_n),
    .push      (push_tag),
    .push_data (push_tag_data),
    .pop       (sram_data_out_valid),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_state_reg   <= CMD_EMPTY;
      ptr_reg         <= '0;
      sram_addr_valid <= 1'b0;
      sram_addr       <= '0;
      sram_data_in    <= '0;
      sram_write_mask <= '0;
      rd_resp_valid   <= '0;
      rd_resp_data    <= '0;
      err_orphan      <= 1'b0;
    end else begin
      if (can_load) begin
        if (gnt_found) begin
          cmd_state_reg   <= CMD_HOLD;
          sram_addr_valid <= 1'b1;
          sram_addr       <= addr_next;
          sram_data_in    <= data_next;
          sram_write_mask <= mask_next;
          ptr_reg         <= ptr_next;
        end else begin
          cmd_state_reg   <= CMD_EMPTY;
          sram_addr_valid <= 1'b0;
        end
      end
      rd_resp_valid <= resp_onehot;
      if (sram_data_out_valid) rd_resp_data <= sram_data_out;
      if (sram_data_out_valid && tag_empty) err_orphan <= 1'b1;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  for (genvar gi = 0; gi < N; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge sram_clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_reg <= '0;
      end else if (stat_clear) begin
        cnt_reg <= '0;
      end else if (grant_ok && (gnt_idx == PTR_W'(gi)) && (cnt_reg != 16'hFFFF)) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
    assign stat_grants[gi*16 +: 16] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter: queue-based reference model plus directed scenarios.
module tb_sram_rr_arbiter;

  localparam int NW = 2, NR = 2, ADDR_W = 18, DATA_W = 32, MASK_W = 4, TAG_DEPTH = 8;
  localparam int N  = NW + NR;
  localparam int EW = MASK_W + ADDR_W + DATA_W;

  logic                 sram_clock = 1'b0;
  logic                 reset_n = 1'b1;
  logic [NW-1:0]        wr_valid, wr_ready;
  logic [NW*EW-1:0]     wr_din;
  logic [NR-1:0]        rd_valid, rd_ready, rd_resp_full, rd_resp_valid;
  logic [NR*ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0]    rd_resp_data, sram_data_in, sram_data_out;
  logic                 sram_addr_valid, sram_ready, sram_data_out_valid, err_orphan;
  logic [ADDR_W-1:0]    sram_addr;
  logic [MASK_W-1:0]    sram_write_mask;
`ifdef SRAM_ARB_STATS_EN
  logic                 stat_clear = 1'b0;
  logic [N*16-1:0]      stat_grants;
`endif

  sram_rr_arbiter #(
    .NW(NW), .NR(NR), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .sram_clock          (sram_clock),
    .reset_n             (reset_n),
    .wr_valid            (wr_valid),
    .wr_ready            (wr_ready),
    .wr_din              (wr_din),
    .rd_valid            (rd_valid),
    .rd_ready            (rd_ready),
    .rd_addr             (rd_addr),
    .rd_resp_full        (rd_resp_full),
    .rd_resp_valid       (rd_resp_valid),
    .rd_resp_data        (rd_resp_data),
    .sram_addr_valid     (sram_addr_valid),
    .sram_ready          (sram_ready),
    .sram_addr           (sram_addr),
    .sram_data_in        (sram_data_in),
    .sram_write_mask     (sram_write_mask),
    .sram_data_out       (sram_data_out),
    .sram_data_out_valid (sram_data_out_valid),
    .err_orphan          (err_orphan)
`ifdef SRAM_ARB_STATS_EN
    , .stat_clear        (stat_clear)
    , .stat_grants       (stat_grants)
`endif
  );

  always #5 sram_clock = ~sram_clock;

  int n_checks = 0;
  int n_errors = 0;
  int gnt_log[$];

  // Reference model state
  bit                m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [MASK_W-1:0] m_mask;
  int                m_ptr;
  int                m_tags[$];
  logic [NR-1:0]     m_resp;
  logic [DATA_W-1:0] m_rdata;
  bit                m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sram_clock);
    #1;
  endtask

  function automatic bit model_elig(input int c);
    if (c < NW) return wr_valid[c];
    return rd_valid[c-NW] && !rd_resp_full[c-NW] && (m_tags.size() < TAG_DEPTH);
  endfunction

  function automatic int cnt(input int c);
    int n = 0;
    foreach (gnt_log[i]) if (gnt_log[i] == c) n++;
    return n;
  endfunction

  // Compare process: check outputs against the model, then advance the model one cycle.
  initial begin
    logic [N-1:0]  rdy_vec, exp_rdy;
    logic [EW-1:0] entry;
    bit            can;
    int            g, c;
    forever begin
      @(negedge sram_clock);
      if (!reset_n) begin
        m_valid = 0; m_ptr = 0; m_tags.delete(); m_resp = '0; m_err = 0; m_rdata = '0;
        chk("reset_outputs", 64'(|{sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
            wr_ready, rd_ready, rd_resp_valid, rd_resp_data, err_orphan}), 64'd0);
      end else begin
        chk("cmd_valid", 64'(sram_addr_valid), 64'(m_valid));
        if (m_valid) begin
          chk("cmd_addr", 64'(sram_addr), 64'(m_addr));
          chk("cmd_data", 64'(sram_data_in), 64'(m_data));
          chk("cmd_mask", 64'(sram_write_mask), 64'(m_mask));
        end
        chk("resp_valid", 64'(rd_resp_valid), 64'(m_resp));
        if (m_resp != '0) chk("resp_data", 64'(rd_resp_data), 64'(m_rdata));
        chk("err_orphan", 64'(err_orphan), 64'(m_err));

        can = !m_valid || sram_ready;
        g = -1;
        if (can) begin
          for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (g < 0 && model_elig(c)) g = c;
          end
        end
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        rdy_vec = {rd_ready, wr_ready};
        chk("ready_vec", 64'(rdy_vec), 64'(exp_rdy));
        for (int k = 0; k < N; k++) if (rdy_vec[k]) gnt_log.push_back(k);

        if (sram_data_out_valid) begin
          if (m_tags.size() > 0) begin
            m_resp  = NR'(1) << m_tags.pop_front();
            m_rdata = sram_data_out;
          end else begin
            m_resp = '0;
            m_err  = 1;
          end
        end else begin
          m_resp = '0;
        end

        if (can) begin
          if (g < 0) begin
            m_valid = 0;
          end else begin
            m_valid = 1;
            m_ptr   = (g + 1) % N;
            if (g < NW) begin
              entry  = wr_din[g*EW +: EW];
              m_mask = entry[EW-1 -: MASK_W];
              m_addr = entry[DATA_W +: ADDR_W];
              m_data = entry[DATA_W-1:0];
            end else begin
              m_mask = '0;
              m_data = '0;
              m_addr = rd_addr[(g-NW)*ADDR_W +: ADDR_W];
              m_tags.push_back(g - NW);
            end
          end
        end
      end
    end
  end

  task automatic drain();
    int n = m_tags.size();
    for (int i = 0; i < n; i++) begin
      sram_data_out_valid = 1'b1;
      sram_data_out       = $urandom;
      step(1);
    end
    sram_data_out_valid = 1'b0;
    step(1);
  endtask

  initial begin
    wr_valid = '0; wr_din = '0; rd_valid = '0; rd_addr = '0; rd_resp_full = '0;
    sram_ready = 1'b1; sram_data_out = '0; sram_data_out_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_cmd_valid", 64'(sram_addr_valid), 64'd0);
    chk("reset_err", 64'(err_orphan), 64'd0);
    step(2);
    reset_n = 1'b1;
    step(1);

    // Rotation with everyone requesting
    gnt_log.delete();
    wr_din  = {4'h1, 18'h00B00, 32'h0000_B0B0, 4'h2, 18'h00A00, 32'h0000_A0A0};
    rd_addr = {18'h00200, 18'h00100};
    wr_valid = '1; rd_valid = '1;
    step(8);
    wr_valid = '0; rd_valid = '0;
    chk("rr_len", 64'(gnt_log.size()), 64'd8);
    for (int k = 0; k < 8; k++)
      chk("rr_order", 64'((gnt_log.size() > k) ? gnt_log[k] : -1), 64'(k % 4));
    step(2);
    drain();

    // Single write, then held under backpressure
    wr_din = '0;
    wr_din[EW +: EW] = {4'hF, 18'h00123, 32'hDEADBEEF};
    wr_valid = 2'b10;
    step(1);
    sram_ready = 1'b0;
    #1;
    chk("wr_cmd_valid", 64'(sram_addr_valid), 64'd1);
    chk("wr_cmd_addr", 64'(sram_addr), 64'h00123);
    chk("wr_cmd_mask", 64'(sram_write_mask), 64'hF);
    chk("wr_cmd_data", 64'(sram_data_in), 64'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("wr_hold_addr", 64'(sram_addr), 64'h00123);
      chk("wr_hold_valid", 64'(sram_addr_valid), 64'd1);
      chk("wr_hold_noready", 64'({rd_ready, wr_ready}), 64'd0);
    end
    sram_ready = 1'b1; wr_valid = '0;
    step(2);
    chk("wr_empty", 64'(sram_addr_valid), 64'd0);

    // Two reads, responses in order
    rd_addr = {18'h00020, 18'h00010};
    rd_valid = 2'b01;
    step(1);
    rd_valid = 2'b10;
    step(1);
    rd_valid = '0;
    chk("rd_cmd_addr", 64'(sram_addr), 64'h00020);
    chk("rd_cmd_mask", 64'(sram_write_mask), 64'd0);
    chk("rd_cmd_data", 64'(sram_data_in), 64'd0);
    step(1);
    sram_data_out_valid = 1'b1; sram_data_out = 32'hAAAA0010;
    step(1);
    sram_data_out_valid = 1'b0;
    chk("rd_resp0_valid", 64'(rd_resp_valid), 64'b01);
    chk("rd_resp0_data", 64'(rd_resp_data), 64'hAAAA0010);
    step(2);
    sram_data_out_valid = 1'b1; sram_data_out = 32'hBBBB0020;
    step(1);
    sram_data_out_valid = 1'b0;
    chk("rd_resp1_valid", 64'(rd_resp_valid), 64'b10);
    chk("rd_resp1_data", 64'(rd_resp_data), 64'hBBBB0020);
    step(1);

    // Tag queue fills; writes continue
    gnt_log.delete();
    wr_din[0 +: EW] = {4'h3, 18'h00777, 32'h12345678};
    wr_valid = 2'b01; rd_valid = 2'b11;
    step(20);
    chk("full_reads", 64'(cnt(2) + cnt(3)), 64'd8);
    chk("full_writes", 64'(cnt(0)), 64'd12);
    gnt_log.delete();
    sram_data_out_valid = 1'b1; sram_data_out = 32'hCAFE0001;
    step(1);
    sram_data_out_valid = 1'b0;
    step(6);
    chk("full_one_more_read", 64'(cnt(2) + cnt(3)), 64'd1);
    wr_valid = '0; rd_valid = '0;
    step(2);
    drain();

    // Reader 0 blocked by downstream prog_full
    rd_resp_full = 2'b01;
    wr_valid = 2'b11; rd_valid = 2'b11;
    gnt_log.delete();
    step(12);
    chk("blk_r0_never", 64'(cnt(2)), 64'd0);
    chk("blk_w0", 64'(cnt(0)), 64'd4);
    chk("blk_w1", 64'(cnt(1)), 64'd4);
    chk("blk_r1", 64'(cnt(3)), 64'd4);
    rd_resp_full = '0;
    gnt_log.delete();
    step(4);
    chk("blk_r0_released", 64'(cnt(2)), 64'd1);
    wr_valid = '0; rd_valid = '0;
    step(2);
    drain();

    // Orphan strobe
    sram_data_out_valid = 1'b1; sram_data_out = 32'h0BAD0BAD;
    step(1);
    sram_data_out_valid = 1'b0;
    chk("orphan_err", 64'(err_orphan), 64'd1);
    chk("orphan_no_resp", 64'(rd_resp_valid), 64'd0);
    step(1);
    chk("orphan_sticky", 64'(err_orphan), 64'd1);

    // Reset in the middle of a burst
    wr_valid = '1; rd_valid = '1;
    step(3);
    chk("burst_active", 64'(sram_addr_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_cmd_valid", 64'(sram_addr_valid), 64'd0);
    chk("rst_ready", 64'({rd_ready, wr_ready}), 64'd0);
    chk("rst_err", 64'(err_orphan), 64'd0);
    chk("rst_addr", 64'(sram_addr), 64'd0);
    step(1);
    reset_n = 1'b1;
    gnt_log.delete();
    step(4);
    for (int k = 0; k < 4; k++)
      chk("rst_ptr_restart", 64'((gnt_log.size() > k) ? gnt_log[k] : -1), 64'(k));
    wr_valid = '0; rd_valid = '0;
    step(2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
